// File: rtl/uart_cmd_responder.sv
// UART command responder: parses read/write frames from an rx FIFO, drives a register bus,
// and returns read data over a tx FIFO. Optional bus timeout via `define CMD_TIMEOUT_EN.
module uart_cmd_responder #(
    parameter logic [7:0] TO_CYCLES = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_rd,
    output logic        rx_re,
    input  logic        rx_emp,
    output logic [7:0]  tx_wd,
    output logic        tx_we,
    input  logic        tx_ful,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    input  logic [15:0] bus_rdata,
    input  logic        bus_ack,
    output logic        busy,
    output logic        err
);

    localparam logic [7:0] OpRead  = 8'h00;
    localparam logic [7:0] OpWrite = 8'h01;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StDecode,
        StBus,
        StTxHi,
        StTxLo
    } state_e;

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic        is_write_q;
    logic [15:0] addr_q;
    logic [15:0] data_q;
    logic [15:0] resp_q;
`ifdef CMD_TIMEOUT_EN
    logic [7:0]  to_cnt_q;
`endif

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            is_write_q <= 1'b0;
            addr_q     <= 16'h0000;
            data_q     <= 16'h0000;
            resp_q     <= 16'h0000;
            rx_re      <= 1'b0;
            tx_we      <= 1'b0;
            tx_wd      <= 8'h00;
            bus_addr   <= 16'h0000;
            bus_wdata  <= 16'h0000;
            bus_we     <= 1'b0;
            bus_re     <= 1'b0;
            err        <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            to_cnt_q   <= 8'h00;
`endif
        end else begin
            // Both FIFO strobes are single-cycle pulses unless re-armed below.
            rx_re <= 1'b0;
            tx_we <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q <= 3'd0;
                    if (!rx_emp) state_q <= StFetch;
                end
                StFetch: begin
                    if (!rx_emp && !rx_re) begin
                        rx_re   <= 1'b1;
                        state_q <= StLatch;
                    end
                end
                StLatch: begin
                    // First LATCH cycle carries the read pulse; data is valid the cycle after.
                    if (!rx_re) begin
                        cnt_q   <= cnt_q + 3'd1;
                        state_q <= StFetch;
                        case (cnt_q)
                            3'd0: begin
                                if (rx_rd == OpWrite) begin
                                    is_write_q <= 1'b1;
                                end else if (rx_rd == OpRead) begin
                                    is_write_q <= 1'b0;
                                end else begin
                                    err     <= 1'b1;
                                    state_q <= StIdle;
                                end
                            end
                            3'd1: addr_q[15:8] <= rx_rd;
                            3'd2: begin
                                addr_q[7:0] <= rx_rd;
                                if (!is_write_q) state_q <= StDecode;
                            end
                            3'd3: data_q[15:8] <= rx_rd;
                            3'd4: begin
                                data_q[7:0] <= rx_rd;
                                state_q     <= StDecode;
                            end
                            default: state_q <= StIdle;
                        endcase
                    end
                end
                StDecode: begin
                    bus_addr <= addr_q;
                    if (is_write_q) begin
                        bus_wdata <= data_q;
                        bus_we    <= 1'b1;
                    end else begin
                        bus_re <= 1'b1;
                    end
`ifdef CMD_TIMEOUT_EN
                    to_cnt_q <= 8'h00;
`endif
                    state_q <= StBus;
                end
                StBus: begin
                    if (bus_ack) begin
                        bus_we <= 1'b0;
                        bus_re <= 1'b0;
                        if (is_write_q) begin
                            state_q <= StIdle;
                        end else begin
                            resp_q  <= bus_rdata;
                            state_q <= StTxHi;
                        end
`ifdef CMD_TIMEOUT_EN
                    end else if (to_cnt_q == TO_CYCLES - 8'd1) begin
                        bus_we <= 1'b0;
                        bus_re <= 1'b0;
                        err    <= 1'b1;
                        if (is_write_q) begin
                            state_q <= StIdle;
                        end else begin
                            resp_q  <= 16'hFFFF;
                            state_q <= StTxHi;
                        end
                    end else begin
                        to_cnt_q <= to_cnt_q + 8'd1;
`endif
                    end
                end
                StTxHi: begin
                    if (!tx_ful && !tx_we) begin
                        tx_we   <= 1'b1;
                        tx_wd   <= resp_q[15:8];
                        state_q <= StTxLo;
                    end
                end
                StTxLo: begin
                    if (!tx_ful && !tx_we) begin
                        tx_we   <= 1'b1;
                        tx_wd   <= resp_q[7:0];
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: FIFO and bus models, a frame-level reference model, and a
// per-cycle compare process. Build with +define+CMD_TIMEOUT_EN to exercise the bus timeout.
module tb_uart_cmd_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_rd = 8'h00;
    logic        rx_re;
    logic        rx_emp = 1'b1;
    logic [7:0]  tx_wd;
    logic        tx_we;
    logic        tx_ful = 1'b0;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [15:0] bus_rdata = 16'h0000;
    logic        bus_ack = 1'b0;
    logic        busy;
    logic        err;

    uart_cmd_responder dut (
        .clk       (clk),
        .rst       (rst),
        .rx_rd     (rx_rd),
        .rx_re     (rx_re),
        .rx_emp    (rx_emp),
        .tx_wd     (tx_wd),
        .tx_we     (tx_we),
        .tx_ful    (tx_ful),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- rx FIFO model ----------------
    logic [7:0] rxq[$];
    always @(posedge clk) begin
        if (rx_re && rxq.size() > 0) rx_rd <= rxq.pop_front();
    end
    always @(negedge clk) rx_emp = (rxq.size() == 0);

    // ---------------- bus slave model ----------------
    logic        ack_en = 1'b1;
    logic        ack_hold = 1'b0;
    int          ack_delay = 1;
    int          ack_wait = 0;
    logic [15:0] rdata_cfg = 16'h0000;
    always @(negedge clk) begin
        bus_rdata = rdata_cfg;
        if (ack_hold) begin
            bus_ack = 1'b1;
        end else if ((bus_we || bus_re) && ack_en) begin
            bus_ack = (ack_wait >= ack_delay);
            ack_wait++;
        end else begin
            bus_ack = 1'b0;
            ack_wait = 0;
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } bus_t;

    bus_t       exp_bus[$];
    logic [7:0] exp_tx[$];
    logic [7:0] fb[$];
    logic       exp_err = 1'b0;
    logic       exp_timeout = 1'b0;

    task automatic model_byte(input logic [7:0] b);
        logic [15:0] resp;
        if (fb.size() == 0 && b != 8'h00 && b != 8'h01) begin
            exp_err = 1'b1;
        end else begin
            fb.push_back(b);
            if (fb[0] == 8'h01 && fb.size() == 5) begin
                exp_bus.push_back({1'b1, fb[1], fb[2], fb[3], fb[4]});
                fb.delete();
            end else if (fb[0] == 8'h00 && fb.size() == 3) begin
                exp_bus.push_back({1'b0, fb[1], fb[2], 16'h0000});
                resp = exp_timeout ? 16'hFFFF : rdata_cfg;
                exp_tx.push_back(resp[15:8]);
                exp_tx.push_back(resp[7:0]);
                if (exp_timeout) exp_err = 1'b1;
                fb.delete();
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        rxq.push_back(b);
        model_byte(b);
    endtask

    task automatic model_reset();
        fb.delete();
        exp_bus.delete();
        exp_tx.delete();
        exp_err = 1'b0;
    endtask

    // ---------------- compare process ----------------
    logic        rx_re_p = 1'b0, tx_we_p = 1'b0, tx_ful_p = 1'b0, strobe_p = 1'b0;
    logic [15:0] addr_p = 16'h0, wdata_p = 16'h0;
    logic        strobe;
    int          cyc = 0;
    int          last_rx_re_cyc = 0;
    int          first_tx_cyc = -1;
    int          strobe_len = 0;
    int          last_strobe_len = 0;
    int          bus_wr_cnt = 0;
    int          bus_rd_cnt = 0;
    logic [15:0] last_addr = 16'h0;
    logic [15:0] last_wdata = 16'h0;
    logic [7:0]  tx_log[$];
    bus_t        e;

    assign strobe = bus_we | bus_re;

    always @(negedge clk) begin
        if (rst) begin
            cyc++;
            chk("strobe_exclusive", {31'd0, bus_we && bus_re}, 0);
            chk("rx_re_back_to_back", {31'd0, rx_re && rx_re_p}, 0);
            chk("tx_we_back_to_back", {31'd0, tx_we && tx_we_p}, 0);
            if (rx_re) begin
                chk("rx_re_on_empty", {31'd0, rxq.size() == 0}, 0);
                last_rx_re_cyc = cyc;
            end
            if (tx_we) begin
                chk("tx_we_while_full", {31'd0, tx_ful_p}, 0);
                tx_log.push_back(tx_wd);
                if (first_tx_cyc < 0) first_tx_cyc = cyc;
                if (exp_tx.size() == 0) chk("tx_unexpected", 1, 0);
                else chk("tx_byte", {24'd0, tx_wd}, {24'd0, exp_tx.pop_front()});
            end
            if (strobe && !strobe_p) begin
                if (bus_we) bus_wr_cnt++;
                else bus_rd_cnt++;
                last_addr = bus_addr;
                last_wdata = bus_wdata;
                if (exp_bus.size() == 0) begin
                    chk("bus_unexpected", 1, 0);
                end else begin
                    e = exp_bus.pop_front();
                    chk("bus_kind", {31'd0, bus_we}, {31'd0, e.we});
                    chk("bus_addr", {16'd0, bus_addr}, {16'd0, e.addr});
                    if (e.we) chk("bus_wdata", {16'd0, bus_wdata}, {16'd0, e.wdata});
                end
            end
            if (strobe && strobe_p) begin
                chk("bus_addr_stable", {16'd0, bus_addr}, {16'd0, addr_p});
                chk("bus_wdata_stable", {16'd0, bus_wdata}, {16'd0, wdata_p});
            end
            if (strobe) strobe_len++;
            else if (strobe_p) begin
                last_strobe_len = strobe_len;
                strobe_len = 0;
            end
            rx_re_p  = rx_re;
            tx_we_p  = tx_we;
            tx_ful_p = tx_ful;
            strobe_p = strobe;
            addr_p   = bus_addr;
            wdata_p  = bus_wdata;
        end else begin
            rx_re_p    = 1'b0;
            tx_we_p    = 1'b0;
            tx_ful_p   = tx_ful;
            strobe_p   = 1'b0;
            strobe_len = 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        tx_log.delete();
        bus_wr_cnt = 0;
        bus_rd_cnt = 0;
        first_tx_cyc = -1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(rxq.size() == 0 && exp_bus.size() == 0 && exp_tx.size() == 0 && !busy)
               && n < 2000) begin
            step(1);
            n++;
        end
        chk({name, "_idle_timeout"}, {31'd0, n >= 2000}, 0);
        step(2);
        chk({name, "_busy"}, {31'd0, busy}, 0);
        chk({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_rx_re"}, {31'd0, rx_re}, 0);
        chk({name, "_tx_we"}, {31'd0, tx_we}, 0);
        chk({name, "_tx_wd"}, {24'd0, tx_wd}, 0);
        chk({name, "_bus_we"}, {31'd0, bus_we}, 0);
        chk({name, "_bus_re"}, {31'd0, bus_re}, 0);
        chk({name, "_bus_addr"}, {16'd0, bus_addr}, 0);
        chk({name, "_bus_wdata"}, {16'd0, bus_wdata}, 0);
        chk({name, "_busy"}, {31'd0, busy}, 0);
        chk({name, "_err"}, {31'd0, err}, 0);
    endtask

    task automatic chk_tx2(input string name, input logic [7:0] hi, input logic [7:0] lo);
        chk({name, "_tx_count"}, tx_log.size(), 2);
        if (tx_log.size() == 2) begin
            chk({name, "_tx_hi"}, {24'd0, tx_log[0]}, {24'd0, hi});
            chk({name, "_tx_lo"}, {24'd0, tx_log[1]}, {24'd0, lo});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        check_reset_vals("reset");
        rst = 1'b1;
        step(2);

        // Write frame, ack one cycle after the strobe.
        clear_logs();
        send(8'h01); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
        wait_idle("write");
        chk("write_count", bus_wr_cnt, 1);
        chk("write_addr", {16'd0, last_addr}, 32'h1234);
        chk("write_wdata", {16'd0, last_wdata}, 32'hABCD);
        chk("write_no_tx", tx_log.size(), 0);
        chk("write_err", {31'd0, err}, 0);

        // Read frame.
        clear_logs();
        rdata_cfg = 16'hBEEF;
        send(8'h00); send(8'h00); send(8'h10);
        wait_idle("read");
        chk("read_count", bus_rd_cnt, 1);
        chk("read_addr", {16'd0, last_addr}, 32'h0010);
        chk_tx2("read", 8'hBE, 8'hEF);

        // Unknown opcode then a valid read.
        clear_logs();
        rdata_cfg = 16'h1357;
        send(8'h7F); send(8'h00); send(8'h00); send(8'h10);
        wait_idle("badop");
        chk("badop_err", {31'd0, err}, 1);
        chk("badop_reads", bus_rd_cnt, 1);
        chk("badop_writes", bus_wr_cnt, 0);
        chk_tx2("badop", 8'h13, 8'h57);

        // tx FIFO full for 20 cycles.
        clear_logs();
        rdata_cfg = 16'hBEEF;
        tx_ful = 1'b1;
        send(8'h00); send(8'h00); send(8'h10);
        step(20);
        chk("full_no_tx", tx_log.size(), 0);
        tx_ful = 1'b0;
        wait_idle("full");
        chk_tx2("full", 8'hBE, 8'hEF);

        // Minimum latency with ack held high: rx_re of last byte to first tx_we is 5 cycles.
        clear_logs();
        rdata_cfg = 16'hC3A5;
        ack_hold = 1'b1;
        send(8'h00); send(8'h00); send(8'h20);
        wait_idle("latency");
        ack_hold = 1'b0;
        chk("latency_cycles", first_tx_cyc - last_rx_re_cyc, 5);
        chk_tx2("latency", 8'hC3, 8'hA5);

        // rx FIFO runs dry mid-frame.
        clear_logs();
        rdata_cfg = 16'h5A3C;
        send(8'h00); send(8'h00);
        step(12);
        chk("stall_busy", {31'd0, busy}, 1);
        chk("stall_no_bus", bus_rd_cnt, 0);
        send(8'h30);
        wait_idle("stall");
        chk("stall_addr", {16'd0, last_addr}, 32'h0030);
        chk_tx2("stall", 8'h5A, 8'h3C);

        // Reset mid write frame.
        clear_logs();
        send(8'h01); send(8'h12);
        step(12);
        chk("midreset_busy", {31'd0, busy}, 1);
        rst = 1'b0;
        #1;
        check_reset_vals("midreset");
        model_reset();
        step(3);
        rst = 1'b1;
        step(2);
        rdata_cfg = 16'hBEEF;
        send(8'h00); send(8'h00); send(8'h10);
        wait_idle("postreset");
        chk("postreset_reads", bus_rd_cnt, 1);
        chk("postreset_writes", bus_wr_cnt, 0);
        chk("postreset_addr", {16'd0, last_addr}, 32'h0010);
        chk_tx2("postreset", 8'hBE, 8'hEF);

`ifdef CMD_TIMEOUT_EN
        // Bus never acknowledges: strobe held 255 cycles, response FFFF, err set.
        clear_logs();
        ack_en = 1'b0;
        exp_timeout = 1'b1;
        send(8'h00); send(8'h00); send(8'h40);
        wait_idle("timeout");
        chk("timeout_strobe_len", last_strobe_len, 255);
        chk("timeout_err", {31'd0, err}, 1);
        chk_tx2("timeout", 8'hFF, 8'hFF);
        ack_en = 1'b1;
        exp_timeout = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
